// File: rtl/quad_step_ctrl_if.sv
// Encoder-side bundle for quad_step_ctrl: channel inputs, controls and step/position outputs.
// The master drives the encoder channels and controls; the slave is the step controller.
interface quad_step_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic             step_up;
    logic             step_dn;
    logic             dir;
    logic [CNT_W-1:0] pos;
    logic             err;
    logic             load;

    modport master (
        output a_in, b_in, en, clr,
        input  step_up, step_dn, dir, pos, err, load
    );

    modport slave (
        input  a_in, b_in, en, clr,
        output step_up, step_dn, dir, pos, err, load
    );
endinterface

// File: rtl/quad_step_ctrl.sv
// Quadrature step controller: resynchronises A/B, tracks the Gray phase, counts detents into a bounded position.
// Optional build macro QUAD_WRAP_EN makes pos wrap at the bounds instead of saturating.
module quad_step_ctrl #(
    parameter int CNT_W            = 8,
    parameter int MAX_COUNT        = 255,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    quad_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P11 = 2'b11,
        P10 = 2'b10
    } phase_e;

    localparam int SUB_W = 4;
    localparam logic signed [SUB_W-1:0] SUB_ZERO = '0;
    localparam logic signed [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic signed [SUB_W-1:0] SUB_MAX  = SUB_W'(STEPS_PER_DETENT);
    localparam logic [CNT_W-1:0]        POS_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]        POS_ONE  = CNT_W'(1);

    if (STEPS_PER_DETENT != 1 && STEPS_PER_DETENT != 2 && STEPS_PER_DETENT != 4) begin : g_bad_spd
        $error("quad_step_ctrl: STEPS_PER_DETENT must be 1, 2 or 4");
    end
    if (CNT_W < 1 || CNT_W > 31 || MAX_COUNT < 1 || MAX_COUNT >= (1 << CNT_W)) begin : g_bad_max
        $error("quad_step_ctrl: MAX_COUNT must be in 1 .. 2**CNT_W-1");
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] fill_q;
    phase_e     ab;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples its predecessor's pre-edge value; blocking would collapse the chain.
            sync1_q <= {bus.a_in, bus.b_in};
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    assign ab = phase_e'(sync2_q);

    // ------------------------------------------------------------------
    // Phase FSM. Priming waits until the synchroniser holds real encoder
    // data, so the reset value of the sync flops is never seen as a jump.
    // ------------------------------------------------------------------
    phase_e phase_q, phase_d;
    logic   primed_q, primed_d;
    logic   mv_up, mv_dn, mv_ill;
    logic [1:0] delta;

    function automatic logic [1:0] gray_idx(input phase_e p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= P00;
            primed_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            primed_q <= primed_d;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        phase_d  = phase_q;
        primed_d = primed_q;
        if (fill_q[1]) begin
            phase_d  = ab;
            primed_d = 1'b1;
        end
    end

    assign delta = gray_idx(ab) - gray_idx(phase_q);

    always_comb begin
        mv_up  = 1'b0;
        mv_dn  = 1'b0;
        mv_ill = 1'b0;
        if (primed_q) begin
            case (delta)
                2'd1:    mv_up  = 1'b1;
                2'd3:    mv_dn  = 1'b1;
                2'd2:    mv_ill = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sub-count accumulation and error flag
    // ------------------------------------------------------------------
    logic signed [SUB_W-1:0] sub_q, sub_d, sub_step;
    logic pend_up_q, pend_up_d;
    logic pend_dn_q, pend_dn_d;
    logic err_q, err_d;

    always_comb begin
        sub_d     = sub_q;
        sub_step  = sub_q;
        pend_up_d = 1'b0;
        pend_dn_d = 1'b0;
        err_d     = err_q;
        if (bus.clr) begin
            sub_d = SUB_ZERO;
            err_d = 1'b0;
        end else if (mv_ill) begin
            sub_d = SUB_ZERO;
            err_d = 1'b1;
        end else if (bus.en && (mv_up || mv_dn)) begin
            // A reversal against a nonzero sub-count restarts it at +-1.
            if (mv_up) sub_step = (sub_q < SUB_ZERO) ? SUB_ONE  : sub_q + SUB_ONE;
            else       sub_step = (sub_q > SUB_ZERO) ? -SUB_ONE : sub_q - SUB_ONE;
            if (sub_step == SUB_MAX) begin
                pend_up_d = 1'b1;
                sub_d     = SUB_ZERO;
            end else if (sub_step == -SUB_MAX) begin
                pend_dn_d = 1'b1;
                sub_d     = SUB_ZERO;
            end else begin
                sub_d = sub_step;
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobes, position and load sequencing
    // ------------------------------------------------------------------
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             chg_q, chg_d;
    logic             load_q;

    always_comb begin
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        if (bus.clr) begin
            pos_d = '0;
        end else if (pend_up_q) begin
            step_up_d = 1'b1;
            dir_d     = 1'b1;
            if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
`ifdef QUAD_WRAP_EN
            else                  pos_d = '0;
`endif
        end else if (pend_dn_q) begin
            step_dn_d = 1'b1;
            dir_d     = 1'b0;
            if (pos_q != '0) pos_d = pos_q - POS_ONE;
`ifdef QUAD_WRAP_EN
            else             pos_d = POS_MAX;
`endif
        end
        chg_d = (pos_d != pos_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q     <= SUB_ZERO;
            pend_up_q <= 1'b0;
            pend_dn_q <= 1'b0;
            err_q     <= 1'b0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            dir_q     <= 1'b0;
            pos_q     <= '0;
            chg_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
            err_q     <= err_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            chg_q     <= chg_d;
            load_q    <= chg_q;
        end
    end

    assign bus.step_up = step_up_q;
    assign bus.step_dn = step_dn_q;
    assign bus.dir     = dir_q;
    assign bus.pos     = pos_q;
    assign bus.err     = err_q;
    assign bus.load    = load_q;

endmodule

// File: tb/tb_quad_step_ctrl.sv
// Directed bench for quad_step_ctrl (default parameters); expectations adapt to QUAD_WRAP_EN.
// A negedge monitor accumulates strobe/load counts; the sequence checks deltas and exact latencies.
module tb_quad_step_ctrl;
    localparam int CNT_W = 8;
    localparam int MAX_COUNT = 255;
    localparam int SPD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    quad_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    quad_step_ctrl #(
        .CNT_W           (CNT_W),
        .MAX_COUNT       (MAX_COUNT),
        .STEPS_PER_DETENT(SPD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int up_cnt = 0, dn_cnt = 0, load_cnt = 0, both_cnt = 0;
    int up0, dn0, ld0;

    always @(negedge clk) begin
        if (bus.step_up) up_cnt <= up_cnt + 1;
        if (bus.step_dn) dn_cnt <= dn_cnt + 1;
        if (bus.load) load_cnt <= load_cnt + 1;
        if (bus.step_up && bus.step_dn) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ab(input logic [1:0] ab, input int hold);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        ticks(hold);
    endtask

    task automatic snap();
        up0 = up_cnt;
        dn0 = dn_cnt;
        ld0 = load_cnt;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        ticks(1);
        bus.clr = 1'b0;
    endtask

    initial begin
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        bus.en   = 1'b1;
        bus.clr  = 1'b0;

        // Reset with encoder held at 11, then release: priming must not step or flag.
        ticks(3);
        check("rst_pos", bus.pos, 0);
        check("rst_strobes", {bus.step_up, bus.step_dn, bus.dir, bus.err, bus.load}, 0);
        rst_n = 1'b1;
        snap();
        ticks(10);
        check("prime_no_step", (up_cnt - up0) + (dn_cnt - dn0), 0);
        check("prime_no_load", load_cnt - ld0, 0);
        check("prime_err", bus.err, 0);
        check("prime_pos", bus.pos, 0);

        // Walk down to 00 and clear the partial sub-count; clr at pos 0 gives no load.
        set_ab(2'b01, 8);
        set_ab(2'b00, 8);
        snap();
        pulse_clr();
        ticks(4);
        check("clr_at0_noload", load_cnt - ld0, 0);

        // One full up detent with exact latency.
        snap();
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        set_ab(2'b10, 8);
        set_ab(2'b00, 3);
        check("up_lat3", bus.step_up, 0);
        ticks(1);
        check("up_lat4", bus.step_up, 1);
        check("up_dir", bus.dir, 1);
        check("up_pos", bus.pos, 1);
        check("up_load_early", bus.load, 0);
        ticks(1);
        check("up_load", bus.load, 1);
        check("up_pulse_width", bus.step_up, 0);
        ticks(1);
        check("up_load_once", bus.load, 0);
        ticks(4);
        check("up_count", up_cnt - up0, 1);

        // Reverse detent back to 0.
        snap();
        set_ab(2'b10, 8);
        set_ab(2'b11, 8);
        set_ab(2'b01, 8);
        set_ab(2'b00, 4);
        check("dn_lat4", bus.step_dn, 1);
        check("dn_pos", bus.pos, 0);
        check("dn_dir", bus.dir, 0);
        ticks(1);
        check("dn_load", bus.load, 1);
        ticks(6);
        check("dn_count", dn_cnt - dn0, 1);

        // Second down detent at the lower bound.
        snap();
        set_ab(2'b10, 8);
        set_ab(2'b11, 8);
        set_ab(2'b01, 8);
        set_ab(2'b00, 8);
        check("bound_dn_count", dn_cnt - dn0, 1);
`ifdef QUAD_WRAP_EN
        check("bound_pos", bus.pos, MAX_COUNT);
        check("bound_load", load_cnt - ld0, 1);
`else
        check("bound_pos", bus.pos, 0);
        check("bound_load", load_cnt - ld0, 0);
`endif

        // Partial reversal: restart at -1, one down step after four down moves.
        pulse_clr();
        ticks(3);
        check("clr_pos", bus.pos, 0);
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        set_ab(2'b10, 8);
        set_ab(2'b00, 8);
        check("pre_rev_pos", bus.pos, 1);
        snap();
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        set_ab(2'b01, 8);
        set_ab(2'b00, 8);
        set_ab(2'b10, 8);
        check("rev_3dn_nostep", dn_cnt - dn0, 0);
        set_ab(2'b11, 8);
        check("rev_4dn_step", dn_cnt - dn0, 1);
        check("rev_pos", bus.pos, 0);
        set_ab(2'b01, 8);
        set_ab(2'b00, 8);
        check("rev_dn_total", dn_cnt - dn0, 1);
        check("rev_no_up", up_cnt - up0, 0);

        // Sub-count is at -2: an up detent restarts at +1 and completes after four moves.
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        set_ab(2'b10, 8);
        set_ab(2'b00, 8);
        check("restart_up_pos", bus.pos, 1);

        // Illegal jump 00 -> 11.
        snap();
        set_ab(2'b11, 2);
        check("ill_err_early", bus.err, 0);
        ticks(1);
        check("ill_err", bus.err, 1);
        ticks(5);
        check("ill_sticky", bus.err, 1);
        check("ill_no_step", (up_cnt - up0) + (dn_cnt - dn0), 0);
        check("ill_pos", bus.pos, 1);
        pulse_clr();
        check("clr_err", bus.err, 0);
        check("clr_pos1", bus.pos, 0);
        check("clr_load_early", bus.load, 0);
        ticks(1);
        check("clr_load", bus.load, 1);
        ticks(1);
        check("clr_load_once", bus.load, 0);

        // en=0 detent is ignored, the next detent with en=1 counts once.
        bus.en = 1'b0;
        snap();
        set_ab(2'b10, 8);
        set_ab(2'b00, 8);
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        check("en0_no_step", up_cnt - up0, 0);
        check("en0_pos", bus.pos, 0);
        bus.en = 1'b1;
        set_ab(2'b10, 8);
        set_ab(2'b00, 8);
        set_ab(2'b01, 8);
        set_ab(2'b11, 8);
        check("en1_step", up_cnt - up0, 1);
        check("en1_pos", bus.pos, 1);
        check("en1_dir", bus.dir, 1);

        // clr in the cycle a down step completes: step discarded, dir kept.
        snap();
        set_ab(2'b01, 8);
        set_ab(2'b00, 8);
        set_ab(2'b10, 8);
        set_ab(2'b11, 2);
        pulse_clr();
        ticks(6);
        check("clr_step_no_dn", dn_cnt - dn0, 0);
        check("clr_step_no_up", up_cnt - up0, 0);
        check("clr_step_pos", bus.pos, 0);
        check("clr_step_dir", bus.dir, 1);

        // Reset mid-operation with encoder at 11.
        rst_n = 1'b0;
        ticks(2);
        check("rst2_state", {bus.dir, bus.err, bus.load, bus.step_up, bus.step_dn}, 0);
        check("rst2_pos", bus.pos, 0);
        rst_n = 1'b1;
        snap();
        ticks(10);
        check("rst2_no_step", (up_cnt - up0) + (dn_cnt - dn0), 0);
        check("rst2_err", bus.err, 0);
        check("strobe_excl", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
